// File: rtl/lcb_responder.sv
// lcb_responder: LCB-side answerer for collector request frames over RS485.
// Parses 4-byte requests {addr, 8'h52, page, addr^cmd^page} from a byte
// receiver. A request for this LCB is answered, after a turnaround delay
// and a driver-enable guard time, with RESP_BYTES bytes read from the local
// sample memory starting at (page*RESP_BYTES) mod 2^ADDR_W.
//
// Optional build macro LCB_RESP_CHECKSUM_EN: append one byte holding the
// mod-256 sum of the data bytes after the last data byte.
//
// Ports:
//   clk        system clock (80 MHz)
//   rst        asynchronous reset, active-low
//   iData      received byte, qualified by the one-cycle strobe iValid
//   oTxData    byte for the UART transmitter, launched by the pulse oTxStart
//   iTxBusy    transmitter busy
//   oDirTX     RS485 driver enable; oDirRX is always its complement
//   oMemAddr   sample memory read address; iMemData is valid one cycle later
//   oBusy      high while a response is being turned around or sent
//   oReqErr    one-cycle pulse on a request with bad command or check byte
module lcb_responder #(
   parameter logic [7:0]  MY_ADDR    = 8'h01,
   parameter int unsigned RESP_BYTES = 16,
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned TURNAROUND = 100,
   parameter int unsigned DIR_GUARD  = 16,
   parameter int unsigned TIMEOUT    = 2000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        iData,
   input  logic              iValid,
   output logic [7:0]        oTxData,
   output logic              oTxStart,
   input  logic              iTxBusy,
   output logic              oDirTX,
   output logic              oDirRX,
   output logic [ADDR_W-1:0] oMemAddr,
   input  logic [7:0]        iMemData,
   output logic              oBusy,
   output logic              oReqErr
);

   localparam logic [7:0]  CMD_READ = 8'h52;
   localparam int unsigned CNT_W    = $clog2(RESP_BYTES + 2);
   localparam int unsigned TMR_MAX0 = (TURNAROUND > DIR_GUARD) ? TURNAROUND : DIR_GUARD;
   localparam int unsigned TMR_MAX  = (TMR_MAX0 > TIMEOUT) ? TMR_MAX0 : TIMEOUT;
   localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      RX,
      TURN,
      GUARD_ON,
      FETCH,
      SEND,
      WAIT_TX,
      GUARD_OFF
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  byteCnt;
   logic [TMR_W-1:0]  tmr;
   logic [7:0]        rxAddr;
   logic [7:0]        rxCmd;
   logic [7:0]        rxPage;
   logic [ADDR_W-1:0] baseAddr;
   logic              txSeen;
`ifdef LCB_RESP_CHECKSUM_EN
   logic [7:0]        chkSum;
`endif

   logic [7:0]        chkByte;
   logic [ADDR_W-1:0] pageBase;
   logic [CNT_W-1:0]  cntNext;

   // Expected check byte, page base address and incremented byte count
   assign chkByte  = rxAddr ^ rxCmd ^ rxPage;
   assign pageBase = ADDR_W'(32'(rxPage) * RESP_BYTES);
   assign cntNext  = byteCnt + CNT_W'(1);

   // Request parser and response sequencer; all outputs registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         byteCnt  <= '0;
         tmr      <= '0;
         rxAddr   <= '0;
         rxCmd    <= '0;
         rxPage   <= '0;
         baseAddr <= '0;
         txSeen   <= 1'b0;
`ifdef LCB_RESP_CHECKSUM_EN
         chkSum   <= '0;
`endif
         oTxData  <= '0;
         oTxStart <= 1'b0;
         oDirTX   <= 1'b0;
         oDirRX   <= 1'b1;
         oMemAddr <= '0;
         oBusy    <= 1'b0;
         oReqErr  <= 1'b0;
      end else begin
         oTxStart <= 1'b0;
         oReqErr  <= 1'b0;
         case (state)
            IDLE: begin
               if (iValid) begin
                  rxAddr  <= iData;
                  byteCnt <= CNT_W'(1);
                  tmr     <= '0;
                  state   <= RX;
               end
            end

            RX: begin
               if (iValid) begin
                  tmr <= '0;
                  case (byteCnt)
                     CNT_W'(1): begin
                        rxCmd   <= iData;
                        byteCnt <= cntNext;
                     end
                     CNT_W'(2): begin
                        rxPage  <= iData;
                        byteCnt <= cntNext;
                     end
                     default: begin
                        // Fourth byte: decide on the complete frame
                        byteCnt <= '0;
                        state   <= IDLE;
                        if (rxAddr == MY_ADDR) begin
                           if (rxCmd != CMD_READ || iData != chkByte) begin
                              oReqErr <= 1'b1;
                           end else begin
                              baseAddr <= pageBase;
                              oBusy    <= 1'b1;
                              state    <= TURN;
`ifdef LCB_RESP_CHECKSUM_EN
                              chkSum   <= '0;
`endif
                           end
                        end
                     end
                  endcase
               end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                  // Inter-byte gap too long: drop the partial frame quietly
                  tmr     <= '0;
                  byteCnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end

            TURN: begin
               if (tmr == TMR_W'(TURNAROUND - 1)) begin
                  tmr    <= '0;
                  oDirTX <= 1'b1;
                  oDirRX <= 1'b0;
                  state  <= GUARD_ON;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end

            GUARD_ON: begin
               if (tmr == TMR_W'(DIR_GUARD - 1)) begin
                  tmr      <= '0;
                  oMemAddr <= baseAddr;
                  state    <= FETCH;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end

            // Address was registered on the previous edge, so data is valid now
            FETCH: begin
               oTxData <= iMemData;
`ifdef LCB_RESP_CHECKSUM_EN
               chkSum  <= chkSum + iMemData;
`endif
               state   <= SEND;
            end

            SEND: begin
               if (!iTxBusy) begin
                  oTxStart <= 1'b1;
                  txSeen   <= 1'b0;
                  state    <= WAIT_TX;
               end
            end

            // A byte is done only after busy has been seen high and then low
            WAIT_TX: begin
               if (!txSeen) begin
                  txSeen <= iTxBusy;
               end else if (!iTxBusy) begin
                  txSeen  <= 1'b0;
                  byteCnt <= cntNext;
                  if (cntNext < CNT_W'(RESP_BYTES)) begin
                     oMemAddr <= oMemAddr + ADDR_W'(1);
                     state    <= FETCH;
                  end
`ifdef LCB_RESP_CHECKSUM_EN
                  else if (cntNext == CNT_W'(RESP_BYTES)) begin
                     oTxData <= chkSum;
                     state   <= SEND;
                  end
`endif
                  else begin
                     tmr   <= '0;
                     state <= GUARD_OFF;
                  end
               end
            end

            GUARD_OFF: begin
               if (tmr == TMR_W'(DIR_GUARD - 1)) begin
                  tmr     <= '0;
                  byteCnt <= '0;
                  oDirTX  <= 1'b0;
                  oDirRX  <= 1'b1;
                  oBusy   <= 1'b0;
                  state   <= IDLE;
               end else begin
                  tmr <= tmr + TMR_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcb_responder.sv
// Bench for lcb_responder: UART transmitter and sample memory models,
// request driver, and a reference model of the expected response bytes.
module tb_lcb_responder;

   localparam logic [7:0]  MY_ADDR    = 8'h01;
   localparam int unsigned RESP_BYTES = 16;
   localparam int unsigned ADDR_W     = 9;
   localparam int unsigned TURNAROUND = 100;
   localparam int unsigned DIR_GUARD  = 16;
   localparam int unsigned TIMEOUT    = 2000;
   localparam int          BYTE_CYC   = 10;
   localparam int          MEM_SIZE   = 1 << ADDR_W;
`ifdef LCB_RESP_CHECKSUM_EN
   localparam int          NB         = RESP_BYTES + 1;
`else
   localparam int          NB         = RESP_BYTES;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [7:0]        iData = 8'h00;
   logic              iValid = 1'b0;
   logic [7:0]        oTxData;
   logic              oTxStart;
   logic              iTxBusy = 1'b0;
   logic              oDirTX;
   logic              oDirRX;
   logic [ADDR_W-1:0] oMemAddr;
   logic [7:0]        iMemData;
   logic              oBusy;
   logic              oReqErr;

   logic [7:0] mem [0:MEM_SIZE-1];
   assign iMemData = mem[oMemAddr];

   always #5 clk = ~clk;

   lcb_responder #(
      .MY_ADDR   (MY_ADDR),
      .RESP_BYTES(RESP_BYTES),
      .ADDR_W    (ADDR_W),
      .TURNAROUND(TURNAROUND),
      .DIR_GUARD (DIR_GUARD),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .iData   (iData),
      .iValid  (iValid),
      .oTxData (oTxData),
      .oTxStart(oTxStart),
      .iTxBusy (iTxBusy),
      .oDirTX  (oDirTX),
      .oDirRX  (oDirRX),
      .oMemAddr(oMemAddr),
      .iMemData(iMemData),
      .oBusy   (oBusy),
      .oReqErr (oReqErr)
   );

   int errors = 0;
   int checks = 0;

   // Monitor state
   int         cyc = 0;
   logic [7:0] rxq [$];
   int         startCnt, firstStartCyc, busyFallCyc, busyCnt, holdIdx;
   int         dirRiseCnt, dirFallCnt, dirRiseCyc, dirFallCyc;
   int         errPulses, errHigh, dirRxBad, startWhileBusy;
   int         lastByteCyc;
   logic       dirPrev = 1'b0;
   logic       errPrev = 1'b0;

   // Transmitter model plus output monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         iTxBusy = 1'b0;
         busyCnt = 0;
      end else if (busyCnt != 0) begin
         busyCnt = busyCnt - 1;
         if (busyCnt == 0) begin
            iTxBusy     = 1'b0;
            busyFallCyc = cyc;
         end
      end
      if (oTxStart) begin
         if (iTxBusy) startWhileBusy = startWhileBusy + 1;
         rxq.push_back(oTxData);
         if (startCnt == 0) firstStartCyc = cyc;
         startCnt = startCnt + 1;
         busyCnt  = BYTE_CYC + ((startCnt == holdIdx) ? 500 : 0);
         iTxBusy  = 1'b1;
      end
      if (oDirTX && !dirPrev) begin dirRiseCnt = dirRiseCnt + 1; dirRiseCyc = cyc; end
      if (!oDirTX && dirPrev) begin dirFallCnt = dirFallCnt + 1; dirFallCyc = cyc; end
      dirPrev = oDirTX;
      if (oDirRX !== ~oDirTX) dirRxBad = dirRxBad + 1;
      if (oReqErr) errHigh = errHigh + 1;
      if (oReqErr && !errPrev) errPulses = errPulses + 1;
      errPrev = oReqErr;
   end

   // Reference: byte i of the answer to a request for 'page'
   function automatic logic [7:0] model_byte(input logic [7:0] page, input int i);
      logic [7:0] s;
      if (i < int'(RESP_BYTES)) return mem[(int'(page) * int'(RESP_BYTES) + i) % MEM_SIZE];
      s = 8'h00;
      for (int k = 0; k < int'(RESP_BYTES); k++)
         s = s + mem[(int'(page) * int'(RESP_BYTES) + k) % MEM_SIZE];
      return s;
   endfunction

   task automatic clear_mon();
      rxq.delete();
      startCnt = 0; firstStartCyc = 0; busyFallCyc = 0; holdIdx = 0;
      dirRiseCnt = 0; dirFallCnt = 0; dirRiseCyc = 0; dirFallCyc = 0;
      errPulses = 0; errHigh = 0; dirRxBad = 0; startWhileBusy = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      iData = b; iValid = 1'b1; lastByteCyc = cyc;
      @(posedge clk); #1;
      iValid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      send_byte(b0); repeat ($urandom_range(0, 8)) @(posedge clk);
      send_byte(b1); repeat ($urandom_range(0, 8)) @(posedge clk);
      send_byte(b2); repeat ($urandom_range(0, 8)) @(posedge clk);
      send_byte(b3);
   endtask

   // Wait (bounded) for the driver enable to drop after a response
   task automatic wait_response(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk); #1;
         if (dirFallCnt != 0) begin ok = 1'b1; break; end
      end
      repeat (4) @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (oTxData !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h want 00", oTxData); end
      checks++; if (oTxStart !== 1'b0) begin errors++; $display("FAIL reset_txstart: got %b want 0", oTxStart); end
      checks++; if (oDirTX !== 1'b0) begin errors++; $display("FAIL reset_dirtx: got %b want 0", oDirTX); end
      checks++; if (oDirRX !== 1'b1) begin errors++; $display("FAIL reset_dirrx: got %b want 1", oDirRX); end
      checks++; if (oMemAddr !== '0) begin errors++; $display("FAIL reset_memaddr: got %0d want 0", oMemAddr); end
      checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oBusy); end
      checks++; if (oReqErr !== 1'b0) begin errors++; $display("FAIL reset_reqerr: got %b want 0", oReqErr); end
      rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      clear_mon();
   endtask

   task automatic test_basic();
      bit ok;
      clear_mon();
      send_frame(MY_ADDR, 8'h52, 8'h02, MY_ADDR ^ 8'h52 ^ 8'h02);
      repeat (10) @(posedge clk); #1;
      checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", oBusy); end
      wait_response(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done: got no response want response"); end
      checks++; if (rxq.size() != NB) begin errors++; $display("FAIL basic_count: got %0d want %0d", rxq.size(), NB); end
      for (int i = 0; i < NB && i < rxq.size(); i++) begin
         checks++;
         if (rxq[i] !== model_byte(8'h02, i)) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, rxq[i], model_byte(8'h02, i)); end
      end
      // Observation offsets: one falling edge before the sampling edge, one after the output edge
      checks++; if (firstStartCyc - lastByteCyc != int'(TURNAROUND + DIR_GUARD) + 4) begin
         errors++; $display("FAIL basic_latency: got %0d want %0d", firstStartCyc - lastByteCyc - 2, TURNAROUND + DIR_GUARD + 2); end
      checks++; if (dirRiseCyc - lastByteCyc != int'(TURNAROUND) + 2) begin
         errors++; $display("FAIL basic_dir_rise: got %0d want %0d", dirRiseCyc - lastByteCyc - 2, TURNAROUND); end
      checks++; if (dirFallCyc - busyFallCyc != int'(DIR_GUARD) + 1) begin
         errors++; $display("FAIL basic_dir_fall: got %0d want %0d", dirFallCyc - busyFallCyc - 1, DIR_GUARD); end
      checks++; if (errPulses != 0) begin errors++; $display("FAIL basic_reqerr: got %0d want 0", errPulses); end
      checks++; if (dirRxBad != 0) begin errors++; $display("FAIL basic_dirrx: got %0d bad cycles want 0", dirRxBad); end
      checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", oBusy); end
   endtask

   task automatic test_wrong_addr();
      bit ok;
      clear_mon();
      send_frame(8'h05, 8'h52, 8'h00, 8'h57);
      repeat (400) @(posedge clk); #1;
      checks++; if (startCnt != 0) begin errors++; $display("FAIL waddr_starts: got %0d want 0", startCnt); end
      checks++; if (dirRiseCnt != 0) begin errors++; $display("FAIL waddr_dirtx: got %0d rises want 0", dirRiseCnt); end
      checks++; if (errPulses != 0) begin errors++; $display("FAIL waddr_reqerr: got %0d want 0", errPulses); end
      clear_mon();
      send_frame(MY_ADDR, 8'h52, 8'h01, MY_ADDR ^ 8'h52 ^ 8'h01);
      wait_response(ok);
      checks++; if (!ok || rxq.size() != NB) begin errors++; $display("FAIL waddr_next_count: got %0d want %0d", rxq.size(), NB); end
      for (int i = 0; i < NB && i < rxq.size(); i++) begin
         checks++;
         if (rxq[i] !== model_byte(8'h01, i)) begin errors++; $display("FAIL waddr_next_byte%0d: got %h want %h", i, rxq[i], model_byte(8'h01, i)); end
      end
   endtask

   task automatic test_bad_request();
      for (int k = 0; k < 2; k++) begin
         clear_mon();
         if (k == 0) send_frame(MY_ADDR, 8'h52, 8'h00, 8'h00);
         else        send_frame(MY_ADDR, 8'h41, 8'h00, 8'h40);
         repeat (400) @(posedge clk); #1;
         checks++; if (errPulses != 1) begin errors++; $display("FAIL bad%0d_pulses: got %0d want 1", k, errPulses); end
         checks++; if (errHigh != 1) begin errors++; $display("FAIL bad%0d_width: got %0d want 1", k, errHigh); end
         checks++; if (startCnt != 0 || dirRiseCnt != 0) begin
            errors++; $display("FAIL bad%0d_tx: got %0d starts %0d dir rises want 0 0", k, startCnt, dirRiseCnt); end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      clear_mon();
      send_byte(MY_ADDR);
      send_byte(8'h52);
      repeat (TIMEOUT + 5) @(posedge clk);
      send_byte(8'h00);
      send_byte(8'h53);
      repeat (TIMEOUT + 100) @(posedge clk); #1;
      checks++; if (startCnt != 0 || dirRiseCnt != 0) begin
         errors++; $display("FAIL timeout_tx: got %0d starts %0d dir rises want 0 0", startCnt, dirRiseCnt); end
      checks++; if (errPulses != 0) begin errors++; $display("FAIL timeout_reqerr: got %0d want 0", errPulses); end
      clear_mon();
      send_frame(MY_ADDR, 8'h52, 8'h00, MY_ADDR ^ 8'h52);
      wait_response(ok);
      checks++; if (!ok || rxq.size() != NB) begin errors++; $display("FAIL timeout_next_count: got %0d want %0d", rxq.size(), NB); end
      for (int i = 0; i < NB && i < rxq.size(); i++) begin
         checks++;
         if (rxq[i] !== model_byte(8'h00, i)) begin errors++; $display("FAIL timeout_next_byte%0d: got %h want %h", i, rxq[i], model_byte(8'h00, i)); end
      end
   endtask

   task automatic test_page_wrap();
      bit ok;
      logic [7:0] pages [2];
      pages[0] = 8'h1F;
      pages[1] = 8'h20;
      for (int p = 0; p < 2; p++) begin
         clear_mon();
         send_frame(MY_ADDR, 8'h52, pages[p], MY_ADDR ^ 8'h52 ^ pages[p]);
         wait_response(ok);
         checks++; if (!ok || rxq.size() != NB) begin errors++; $display("FAIL page%h_count: got %0d want %0d", pages[p], rxq.size(), NB); end
         for (int i = 0; i < NB && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== model_byte(pages[p], i)) begin errors++; $display("FAIL page%h_byte%0d: got %h want %h", pages[p], i, rxq[i], model_byte(pages[p], i)); end
         end
      end
   endtask

   task automatic test_busy_stretch();
      bit ok;
      clear_mon();
      holdIdx = 7;
      send_frame(MY_ADDR, 8'h52, 8'h05, MY_ADDR ^ 8'h52 ^ 8'h05);
      wait_response(ok);
      checks++; if (!ok || rxq.size() != NB) begin errors++; $display("FAIL stretch_count: got %0d want %0d", rxq.size(), NB); end
      for (int i = 0; i < NB && i < rxq.size(); i++) begin
         checks++;
         if (rxq[i] !== model_byte(8'h05, i)) begin errors++; $display("FAIL stretch_byte%0d: got %h want %h", i, rxq[i], model_byte(8'h05, i)); end
      end
      checks++; if (startWhileBusy != 0) begin errors++; $display("FAIL stretch_overlap: got %0d starts while busy want 0", startWhileBusy); end
   endtask

   task automatic test_random();
      bit ok;
      logic [7:0] b0, b1, b2, b3;
      int kind;
      for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
      for (int f = 0; f < 10; f++) begin
         kind = $urandom_range(0, 3);
         b0 = MY_ADDR;
         b1 = 8'h52;
         b2 = 8'($urandom_range(0, 255));
         if (kind == 1) b0 = 8'($urandom_range(2, 255));
         if (kind == 2) begin b1 = 8'($urandom); if (b1 == 8'h52) b1 = 8'h53; end
         b3 = b0 ^ b1 ^ b2;
         if (kind == 3) b3 = b3 ^ 8'($urandom_range(1, 255));
         clear_mon();
         send_frame(b0, b1, b2, b3);
         if (kind == 0) begin
            wait_response(ok);
            checks++; if (!ok || rxq.size() != NB) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", f, rxq.size(), NB); end
            for (int i = 0; i < NB && i < rxq.size(); i++) begin
               checks++;
               if (rxq[i] !== model_byte(b2, i)) begin errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, i, rxq[i], model_byte(b2, i)); end
            end
         end else begin
            repeat (300) @(posedge clk); #1;
            checks++; if (startCnt != 0) begin errors++; $display("FAIL rand%0d_starts: got %0d want 0", f, startCnt); end
         end
         checks++; if (errPulses != ((kind >= 2) ? 1 : 0)) begin
            errors++; $display("FAIL rand%0d_reqerr: got %0d want %0d", f, errPulses, (kind >= 2) ? 1 : 0); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit reached;
      clear_mon();
      reached = 1'b0;
      send_frame(MY_ADDR, 8'h52, 8'h00, MY_ADDR ^ 8'h52);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (startCnt >= 5) begin reached = 1'b1; break; end
      end
      checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach: got %0d starts want 5", startCnt); end
      rst = 1'b0;
      #1;
      checks++; if (oDirTX !== 1'b0) begin errors++; $display("FAIL rstmid_dirtx: got %b want 0", oDirTX); end
      checks++; if (oTxStart !== 1'b0) begin errors++; $display("FAIL rstmid_txstart: got %b want 0", oTxStart); end
      checks++; if (oDirRX !== 1'b1 || oBusy !== 1'b0) begin errors++; $display("FAIL rstmid_rx_busy: got %b %b want 1 0", oDirRX, oBusy); end
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      repeat (5) @(posedge clk); #1;
      clear_mon();
      send_frame(MY_ADDR, 8'h52, 8'h03, MY_ADDR ^ 8'h52 ^ 8'h03);
      wait_response(ok);
      checks++; if (!ok || rxq.size() != NB) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", rxq.size(), NB); end
      for (int i = 0; i < NB && i < rxq.size(); i++) begin
         checks++;
         if (rxq[i] !== model_byte(8'h03, i)) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, rxq[i], model_byte(8'h03, i)); end
      end
   endtask

   initial begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'(i);
      clear_mon();
      test_reset();
      test_basic();
      test_wrong_addr();
      test_bad_request();
      test_timeout();
      test_page_wrap();
      test_busy_stretch();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
